// File: rtl/mips_periph_pkg.sv
// Shared definitions for the memory-mapped MIPS peripherals: window bases,
// TC register offsets, CTRL bit positions and the timer run state.
package mips_periph_pkg;

    localparam logic [19:0] TC_BASE   = 20'hFFFF0;
    localparam logic [19:0] UART_BASE = 20'hFFFF1;
    localparam logic [19:0] GPIO_BASE = 20'hFFFF2;

    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_LOAD   = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;
    localparam logic [1:0] TC_STATUS = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_PSC_LSB = 8;

    // The run state doubles as the CTRL.EN bit.
    typedef enum logic {
        TC_IDLE = 1'b0,
        TC_RUN  = 1'b1
    } tc_state_e;

endpackage

// File: rtl/tc_prescaler.sv
// Free-running prescale counter: emits a one-cycle tick when the count
// matches the programmed compare value, then restarts from zero.
module tc_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] cnt_q;
    logic [PSC_W-1:0] cnt_d;
    logic             match;

    assign match = (cnt_q == psc);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = match ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the same cycle suppresses the tick so the restart is clean.
    assign tick = en & match & ~clr;

endmodule

// File: rtl/timer_counter.sv
// TC peripheral: down-counting timer with reload, prescaler, expiry flag
// (write-1-to-clear) and a registered level interrupt.
module timer_counter
    import mips_periph_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS_N,
    input  logic        WE,
    input  logic [3:0]  Addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        IRQ
);

    tc_state_e        state_q, state_d;
    logic             auto_q, auto_d;
    logic             ie_q, ie_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             exp_q, exp_d;
    logic             irq_q, irq_d;

    logic [1:0]  word;
    logic        wr_en, rd_en;
    logic        wr_ctrl, wr_load, wr_count, wr_status;
    logic        tick, expire;
    logic [31:0] rd_data;
    logic        unused_addr_bits;

    assign word             = Addr[3:2];
    assign unused_addr_bits = ^Addr[1:0];
    assign wr_en            = ~CS_N & WE;
    assign rd_en            = ~CS_N & ~WE & ~reset;
    assign wr_ctrl          = wr_en & (word == TC_CTRL);
    assign wr_load          = wr_en & (word == TC_LOAD);
    assign wr_count         = wr_en & (word == TC_COUNT);
    assign wr_status        = wr_en & (word == TC_STATUS);

    tc_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == TC_RUN),
        .clr   (wr_count),
        .psc   (psc_q),
        .tick  (tick)
    );

    // A software COUNT write in the same cycle overrides the tick entirely.
    assign expire = tick & ~wr_count & (count_q == '0);

    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        psc_d   = psc_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;
        irq_d   = exp_q & ie_q;

        case (state_q)
            TC_RUN:  if (expire && !auto_q) state_d = TC_IDLE;
            default: ;
        endcase

        if (wr_ctrl) begin
            state_d = DataIn[CTRL_EN] ? TC_RUN : TC_IDLE;
            auto_d  = DataIn[CTRL_AUTO];
            ie_d    = DataIn[CTRL_IE];
            psc_d   = DataIn[CTRL_PSC_LSB +: PSC_W];
        end

        if (wr_load) begin
            load_d = DataIn[CNT_W-1:0];
        end

        if (wr_count) begin
            count_d = DataIn[CNT_W-1:0];
        end else if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else if (auto_q) begin
                count_d = load_q;
            end
        end

        // Set has priority over the write-1-to-clear.
        if (wr_status && DataIn[0]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TC_IDLE;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            psc_q   <= '0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            psc_q   <= psc_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (word)
            TC_CTRL: begin
                rd_data[CTRL_EN]                   = (state_q == TC_RUN);
                rd_data[CTRL_AUTO]                 = auto_q;
                rd_data[CTRL_IE]                   = ie_q;
                rd_data[CTRL_PSC_LSB +: PSC_W]     = psc_q;
            end
            TC_LOAD:   rd_data[CNT_W-1:0] = load_q;
            TC_COUNT:  rd_data[CNT_W-1:0] = count_q;
            TC_STATUS: rd_data[0]         = exp_q;
            default:   rd_data = '0;
        endcase
    end

    assign DataOut = rd_en ? rd_data : 32'h0;
    assign IRQ     = irq_q;

endmodule
